mmio_router: RTL and testbench

MMIO_ROUTER -- requirements
Module: mmio_router

---
 rtl/mmio_router_pkg.sv | 24 ++
 rtl/mmio_router_if.sv | 51 +++++
 rtl/mmio_write_slot.sv | 60 ++++++
 rtl/mmio_router.sv | 131 +++++++++++++
 tb/tb_mmio_router.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_router_pkg.sv
// Shared types for the MMIO router: select width, read FSM states and the write packet.
// The packet struct is sized by MMIO_INDEX_WIDTH/MMIO_DATA_WIDTH, which the router's width parameters default to.
package mmio_router_pkg;

  localparam int SEL_WIDTH        = 2;
  localparam int MMIO_INDEX_WIDTH = 32;
  localparam int MMIO_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_RESPOND = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [MMIO_INDEX_WIDTH-1:0] index;
    logic [MMIO_DATA_WIDTH-1:0]  data;
  } wr_pkt_t;

  function automatic logic [SEL_WIDTH-1:0] dev_sel(input logic [MMIO_INDEX_WIDTH-1:0] index);
    return index[MMIO_INDEX_WIDTH-1 -: SEL_WIDTH];
  endfunction

endpackage

// File: rtl/mmio_router_if.sv
// Host-side and device-side MMIO signals of the router, bundled in one interface.
// slave is the router's view; master is the surrounding host/device environment.
interface mmio_router_if #(
  parameter int INDEX_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_DEVICES = 3
);

  logic                                    host_write_req;
  logic [INDEX_WIDTH-1:0]                  host_write_index;
  logic [DATA_WIDTH-1:0]                   host_write_data;
  logic                                    host_write_ack;
  logic                                    host_read_req;
  logic [INDEX_WIDTH-1:0]                  host_read_index;
  logic                                    host_read_ack;
  logic [DATA_WIDTH-1:0]                   host_read_data;
  logic [NUM_DEVICES-1:0]                  dev_write_req;
  logic [INDEX_WIDTH-1:0]                  dev_write_index;
  logic [DATA_WIDTH-1:0]                   dev_write_data;
  logic [NUM_DEVICES-1:0]                  dev_write_ack;
  logic [NUM_DEVICES-1:0]                  dev_read_req;
  logic [INDEX_WIDTH-1:0]                  dev_read_index;
  logic [NUM_DEVICES-1:0]                  dev_read_ack;
  logic [NUM_DEVICES-1:0][DATA_WIDTH-1:0]  dev_read_data;
  logic [7:0]                              decode_error_count;

  modport slave (
    input  host_write_req, host_write_index, host_write_data,
    output host_write_ack,
    input  host_read_req, host_read_index,
    output host_read_ack, host_read_data,
    output dev_write_req, dev_write_index, dev_write_data,
    input  dev_write_ack,
    output dev_read_req, dev_read_index,
    input  dev_read_ack, dev_read_data,
    output decode_error_count
  );

  modport master (
    output host_write_req, host_write_index, host_write_data,
    input  host_write_ack,
    output host_read_req, host_read_index,
    input  host_read_ack, host_read_data,
    input  dev_write_req, dev_write_index, dev_write_data,
    output dev_write_ack,
    input  dev_read_req, dev_read_index,
    output dev_read_ack, dev_read_data,
    input  decode_error_count
  );

endinterface

// File: rtl/mmio_write_slot.sv
// One-entry write holding register with zero-bubble replacement: a drain and a new load
// in the same cycle keep the slot valid with the new packet.
module mmio_write_slot
  import mmio_router_pkg::*;
#(
  parameter int NUM_DEVICES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_i,
  input  wr_pkt_t                pkt_i,
  input  logic [NUM_DEVICES-1:0] dev_ack_i,
  output logic [NUM_DEVICES-1:0] dev_req_o,
  output wr_pkt_t                pkt_o,
  output logic                   valid_o,
  output logic                   ready_o
);

  logic                 valid_q, valid_d;
  wr_pkt_t              pkt_q, pkt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 drain;

  always_comb begin
    dev_req_o = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      dev_req_o[i] = valid_q && (sel_q == SEL_WIDTH'(i));
    end
  end

  assign drain   = |(dev_req_o & dev_ack_i);
  assign ready_o = !valid_q || drain;
  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

  // load_i is only raised by the router when ready_o is high
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    sel_d   = sel_q;
    if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
      sel_d   = dev_sel(pkt_i.index);
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    pkt_q <= pkt_d;
    sel_q <= sel_d;
  end

endmodule

// File: rtl/mmio_router.sv
// Routes host MMIO reads/writes to one of NUM_DEVICES devices by the top two index bits.
// Writes go through a one-entry skid slot; reads wait for that slot to drain first.
module mmio_router
  import mmio_router_pkg::*;
#(
  parameter int INDEX_WIDTH = MMIO_INDEX_WIDTH,
  parameter int DATA_WIDTH  = MMIO_DATA_WIDTH,
  parameter int NUM_DEVICES = 3
) (
  input  logic          clock,
  input  logic          reset,
  mmio_router_if.slave  bus
);

  logic [SEL_WIDTH-1:0]   wr_sel, rd_sel;
  logic                   wr_mapped, rd_mapped;
  logic                   slot_ready, slot_valid, wr_load, rd_launch, rd_hit;
  wr_pkt_t                wr_pkt_in, wr_pkt_out;
  logic [NUM_DEVICES-1:0] wr_dev_req, rd_onehot;
  logic [DATA_WIDTH-1:0]  rd_capture;
  logic [1:0]             err_inc;
  logic [8:0]             err_sum;

  rd_state_e              rd_state_q;
  logic [INDEX_WIDTH-1:0] rd_index_q;
  logic [NUM_DEVICES-1:0] dev_read_req_q;
  logic                   host_read_ack_q;
  logic [DATA_WIDTH-1:0]  host_read_data_q;
  logic [7:0]             err_cnt_q, err_cnt_d;

  assign wr_sel    = bus.host_write_index[INDEX_WIDTH-1 -: SEL_WIDTH];
  assign rd_sel    = bus.host_read_index[INDEX_WIDTH-1 -: SEL_WIDTH];
  assign wr_mapped = int'(wr_sel) < NUM_DEVICES;
  assign rd_mapped = int'(rd_sel) < NUM_DEVICES;

  assign bus.host_write_ack = bus.host_write_req && slot_ready;
  assign wr_load            = bus.host_write_ack && wr_mapped;
  assign wr_pkt_in          = '{index: bus.host_write_index, data: bus.host_write_data};

  mmio_write_slot #(
    .NUM_DEVICES (NUM_DEVICES)
  ) u_write_slot (
    .clock     (clock),
    .reset     (reset),
    .load_i    (wr_load),
    .pkt_i     (wr_pkt_in),
    .dev_ack_i (bus.dev_write_ack),
    .dev_req_o (wr_dev_req),
    .pkt_o     (wr_pkt_out),
    .valid_o   (slot_valid),
    .ready_o   (slot_ready)
  );

  assign bus.dev_write_req   = wr_dev_req;
  assign bus.dev_write_index = wr_pkt_out.index;
  assign bus.dev_write_data  = wr_pkt_out.data;

  // A read only launches once no write is held, so it always observes earlier writes.
  assign rd_launch = (rd_state_q == RD_IDLE) && bus.host_read_req && !host_read_ack_q && !slot_valid;

  always_comb begin
    rd_onehot  = '0;
    rd_capture = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      rd_onehot[i] = (rd_sel == SEL_WIDTH'(i));
      if (dev_read_req_q[i] && bus.dev_read_ack[i]) begin
        rd_capture = rd_capture | bus.dev_read_data[i];
      end
    end
  end

  // Acks from devices other than the one being read are masked out here.
  assign rd_hit = |(dev_read_req_q & bus.dev_read_ack);

  assign err_inc   = {1'b0, bus.host_write_ack && !wr_mapped} + {1'b0, rd_launch && !rd_mapped};
  assign err_sum   = {1'b0, err_cnt_q} + {7'b0, err_inc};
  assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q       <= RD_IDLE;
      rd_index_q       <= '0;
      dev_read_req_q   <= '0;
      host_read_ack_q  <= 1'b0;
      host_read_data_q <= '0;
      err_cnt_q        <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      case (rd_state_q)
        RD_IDLE: begin
          host_read_ack_q <= 1'b0;
          if (rd_launch) begin
            rd_index_q <= bus.host_read_index;
            if (rd_mapped) begin
              dev_read_req_q <= rd_onehot;
              rd_state_q     <= RD_ISSUE;
            end else begin
              host_read_data_q <= '0;
              host_read_ack_q  <= 1'b1;
              rd_state_q       <= RD_RESPOND;
            end
          end
        end
        RD_ISSUE: begin
          if (rd_hit) begin
            host_read_data_q <= rd_capture;
            dev_read_req_q   <= '0;
            host_read_ack_q  <= 1'b1;
            rd_state_q       <= RD_RESPOND;
          end
        end
        RD_RESPOND: begin
          host_read_ack_q <= 1'b0;
          rd_state_q      <= RD_IDLE;
        end
        default: begin
          dev_read_req_q  <= '0;
          host_read_ack_q <= 1'b0;
          rd_state_q      <= RD_IDLE;
        end
      endcase
    end
  end

  assign bus.dev_read_req       = dev_read_req_q;
  assign bus.dev_read_index     = rd_index_q;
  assign bus.host_read_ack      = host_read_ack_q;
  assign bus.host_read_data     = host_read_data_q;
  assign bus.decode_error_count = err_cnt_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed and randomized checks of mmio_router against a transaction-level model:
// an in-order queue of expected device writes and a saturating unmapped-access counter.
module tb_mmio_router;

  localparam int IW = 32;
  localparam int DW = 32;
  localparam int ND = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mmio_router_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .NUM_DEVICES(ND)) bus ();

  mmio_router #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .NUM_DEVICES(ND)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] idx;
    logic [31:0] dat;
  } wr_t;

  wr_t          wq[$];
  int           exp_err;
  int           n_wr_xfers;
  int           vectors;
  int           miscompares;
  logic         wack_seen, rack_seen;
  logic [31:0]  rdata_seen;
  logic [ND-1:0] wreq_seen;

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  function automatic logic [ND-1:0] onehot_of(input logic [31:0] idx);
    logic [ND-1:0] v;
    int s;
    v = '0;
    s = int'(idx[31:30]);
    if (s < ND) v[s] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score device-side writes, model host-side accepts.
  task automatic tick();
    wr_t e;
    @(negedge clock);
    wack_seen  = bus.host_write_ack;
    rack_seen  = bus.host_read_ack;
    rdata_seen = bus.host_read_data;
    wreq_seen  = bus.dev_write_req;
    for (int d = 0; d < ND; d++) begin
      if (bus.dev_write_req[d] && bus.dev_write_ack[d]) begin
        n_wr_xfers++;
        if (wq.size() == 0) begin
          check("wr_unexpected", 64'(1), 64'(0));
        end else begin
          e = wq.pop_front();
          check("wr_dev", 64'(d), 64'(e.idx[31:30]));
          check("wr_index", 64'(bus.dev_write_index), 64'(e.idx));
          check("wr_data", 64'(bus.dev_write_data), 64'(e.dat));
        end
      end
    end
    if (!reset && bus.host_write_req && bus.host_write_ack) begin
      if (int'(bus.host_write_index[31:30]) < ND) wq.push_back('{bus.host_write_index, bus.host_write_data});
      else exp_err = sat_add(exp_err, 1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.host_write_req = 1'b0;
    bus.host_read_req  = 1'b0;
    bus.dev_write_ack  = '0;
    bus.dev_read_ack   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wq.delete();
    exp_err = 0;
  endtask

  task automatic do_read(input logic [31:0] idx, input int lat, input logic [31:0] data, input bit chk_lat);
    int sel, cnt, n, other;
    bit mapped, got;
    logic [ND-1:0] oh;
    logic [31:0] exp_d;
    sel    = int'(idx[31:30]);
    mapped = (sel < ND);
    oh     = onehot_of(idx);
    other  = (sel + 1) % ND;
    exp_d  = mapped ? data : 32'h0;
    cnt = 0; n = 0; got = 1'b0;
    if (!mapped) exp_err = sat_add(exp_err, 1);
    bus.host_read_req   = 1'b1;
    bus.host_read_index = idx;
    bus.dev_read_ack    = '0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (rack_seen) begin
        got = 1'b1;
      end else begin
        bus.dev_read_ack = '0;
        if (bus.dev_read_req != '0) begin
          check("rd_req_sel", 64'(bus.dev_read_req), 64'(oh));
          check("rd_index", 64'(bus.dev_read_index), 64'(idx));
          cnt++;
          bus.dev_read_ack[other]  = 1'b1;
          bus.dev_read_data[other] = ~data;
          if (cnt == lat + 1) begin
            bus.dev_read_ack[sel]  = 1'b1;
            bus.dev_read_data[sel] = data;
          end
        end
      end
    end
    bus.host_read_req = 1'b0;
    bus.dev_read_ack  = '0;
    check("rd_ack_seen", 64'(got), 64'(1));
    check("rd_data", 64'(rdata_seen), 64'(exp_d));
    if (chk_lat) check("rd_latency", 64'(n - 1), 64'(mapped ? lat + 2 : 1));
    tick();
    check("rd_ack_one_cycle", 64'(rack_seen), 64'(0));
    check("rd_data_hold", 64'(bus.host_read_data), 64'(exp_d));
    check("rd_err_cnt", 64'(bus.decode_error_count), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] b2b_idx [4];
    logic [31:0] ridx;
    bit done;

    vectors = 0; miscompares = 0; n_wr_xfers = 0; exp_err = 0;
    bus.host_write_req = 1'b0; bus.host_write_index = '0; bus.host_write_data = '0;
    bus.host_read_req = 1'b0;  bus.host_read_index = '0;
    bus.dev_write_ack = '0; bus.dev_read_ack = '0; bus.dev_read_data = '0;
    apply_reset();

    check("rst_dev_write_req", 64'(bus.dev_write_req), 64'(0));
    check("rst_dev_read_req", 64'(bus.dev_read_req), 64'(0));
    check("rst_host_read_ack", 64'(bus.host_read_ack), 64'(0));
    check("rst_host_read_data", 64'(bus.host_read_data), 64'(0));
    check("rst_dev_read_index", 64'(bus.dev_read_index), 64'(0));
    check("rst_err_cnt", 64'(bus.decode_error_count), 64'(0));

    // single write to device 1, device acks in its second request cycle
    bus.host_write_req = 1'b1; bus.host_write_index = 32'h4000_0010; bus.host_write_data = 32'h0000_A5A5;
    tick();
    check("w1_first_ack", 64'(wack_seen), 64'(1));
    check("w1_no_req_yet", 64'(wreq_seen), 64'(0));
    bus.host_write_req = 1'b0;
    tick();
    check("w1_req", 64'(wreq_seen), 64'(3'b010));
    check("w1_index", 64'(bus.dev_write_index), 64'(32'h4000_0010));
    check("w1_data", 64'(bus.dev_write_data), 64'(32'h0000_A5A5));
    bus.dev_write_ack = 3'b010;
    tick();
    check("w1_req_held", 64'(wreq_seen), 64'(3'b010));
    bus.dev_write_ack = '0;
    tick();
    check("w1_drained", 64'(wreq_seen), 64'(0));
    check("w1_queue", 64'(wq.size()), 64'(0));

    // back-to-back writes, devices always ready
    b2b_idx = '{32'h0000_0100, 32'h8000_0200, 32'h0000_0300, 32'h8000_0400};
    bus.dev_write_ack = 3'b111;
    n_wr_xfers = 0;
    for (int k = 0; k < 4; k++) begin
      bus.host_write_req = 1'b1; bus.host_write_index = b2b_idx[k]; bus.host_write_data = 32'h2500 + k;
      tick();
      check("b2b_ack", 64'(wack_seen), 64'(1));
      if (k > 0) check("b2b_nobubble", 64'(wreq_seen), 64'(onehot_of(b2b_idx[k-1])));
    end
    bus.host_write_req = 1'b0;
    tick();
    check("b2b_last", 64'(wreq_seen), 64'(onehot_of(b2b_idx[3])));
    tick();
    check("b2b_idle", 64'(wreq_seen), 64'(0));
    check("b2b_xfers", 64'(n_wr_xfers), 64'(4));
    check("b2b_queue", 64'(wq.size()), 64'(0));
    bus.dev_write_ack = '0;

    // mapped read, device 2 acks 3 cycles after request
    do_read(32'h8000_0004, 3, 32'h0000_1234, 1'b1);

    // simultaneous unmapped read and write
    bus.host_write_req = 1'b1; bus.host_write_index = 32'hC000_0000; bus.host_write_data = 32'hDEAD;
    bus.host_read_req  = 1'b1; bus.host_read_index  = 32'hC000_0000;
    exp_err = sat_add(exp_err, 1);
    tick();
    check("unm_wack", 64'(wack_seen), 64'(1));
    check("unm_no_rack_yet", 64'(rack_seen), 64'(0));
    bus.host_write_req = 1'b0;
    tick();
    bus.host_read_req = 1'b0;
    check("unm_rack", 64'(rack_seen), 64'(1));
    check("unm_rdata", 64'(rdata_seen), 64'(0));
    check("unm_dropped", 64'(wreq_seen), 64'(0));
    check("unm_cnt", 64'(bus.decode_error_count), 64'(exp_err));
    check("unm_cnt_two", 64'(bus.decode_error_count), 64'(2));
    tick();

    // read behind a stalled write
    bus.dev_write_ack = '0;
    bus.host_write_req = 1'b1; bus.host_write_index = 32'h0000_0040; bus.host_write_data = 32'h28;
    tick();
    bus.host_write_req = 1'b0;
    bus.host_read_req = 1'b1; bus.host_read_index = 32'h4000_0044;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ord_blocked", 64'(bus.dev_read_req), 64'(0));
      check("ord_no_rack", 64'(rack_seen), 64'(0));
    end
    bus.dev_write_ack = 3'b111;
    do_read(32'h4000_0044, 1, 32'hBEEF, 1'b0);
    check("ord_queue", 64'(wq.size()), 64'(0));

    // reset while a read is in ISSUE and a write is held
    bus.dev_write_ack = '0;
    bus.host_read_req = 1'b1; bus.host_read_index = 32'h0000_0008;
    tick();
    check("rst_issue_req", 64'(bus.dev_read_req), 64'(3'b001));
    bus.host_write_req = 1'b1; bus.host_write_index = 32'h8000_0008; bus.host_write_data = 32'h29;
    tick();
    check("rst_issue_wack", 64'(wack_seen), 64'(1));
    bus.host_write_req = 1'b0; bus.host_read_req = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_rd_req", 64'(bus.dev_read_req), 64'(0));
    check("rst_mid_wr_req", 64'(bus.dev_write_req), 64'(0));
    check("rst_mid_rack", 64'(bus.host_read_ack), 64'(0));
    check("rst_mid_cnt", 64'(bus.decode_error_count), 64'(0));
    reset = 1'b0;
    wq.delete();
    exp_err = 0;
    tick();
    check("rst_mid_no_ack", 64'(rack_seen), 64'(0));
    do_read(32'hC000_0010, 0, 32'h0, 1'b1);

    // saturation of the error counter
    bus.host_write_req = 1'b1; bus.host_write_index = 32'hE000_0000; bus.host_write_data = 32'h0;
    repeat (260) tick();
    bus.host_write_req = 1'b0;
    tick();
    check("sat_cnt", 64'(bus.decode_error_count), 64'(255));
    check("sat_model", 64'(bus.decode_error_count), 64'(exp_err));
    bus.host_write_req = 1'b1; bus.host_read_req = 1'b1; bus.host_read_index = 32'hC000_0004;
    tick();
    bus.host_write_req = 1'b0;
    tick();
    bus.host_read_req = 1'b0;
    check("sat_rd_rack", 64'(rack_seen), 64'(1));
    tick();
    check("sat_hold", 64'(bus.decode_error_count), 64'(255));

    // randomized mix of writes (random device stalls) and reads (random latency)
    apply_reset();
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        bus.host_write_req = 1'b1; bus.host_write_index = $urandom; bus.host_write_data = $urandom;
        done = 1'b0;
        for (int w = 0; w < 40 && !done; w++) begin
          bus.dev_write_ack = 3'($urandom);
          tick();
          done = wack_seen;
        end
        bus.host_write_req = 1'b0;
        check("rnd_wack", 64'(done), 64'(1));
      end else begin
        bus.dev_write_ack = '1;
        tick();
        tick();
        check("rnd_pre_drain", 64'(bus.dev_write_req), 64'(0));
        bus.dev_write_ack = '0;
        ridx = $urandom;
        do_read(ridx, int'($urandom_range(0, 4)), $urandom, 1'b1);
      end
    end
    bus.dev_write_ack = '1;
    tick();
    tick();
    check("rnd_queue_empty", 64'(wq.size()), 64'(0));
    check("rnd_err_cnt", 64'(bus.decode_error_count), 64'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
